fetch_controller: RTL

Instruction-fetch sequencer that closes the loop around the program counter: it reads the current PC, issues one instruction-memory request at a time, and returns fetched words to decode through a one-entry output buffer. It also drives the PC's next-value and write-enable inputs, advancing to PC+4 on each completed fetch or loading a redirect target. It sits in the IF stage between the program counter, instruction memory and the IF/ID boundary, and is the sole writer of the PC.

---
 rtl/fetch_controller.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/fetch_controller.sv
// IF-stage fetch sequencer: issues one instruction-memory request at a time, buffers the
// returned word for decode, and is the sole writer of the program counter.
module fetch_controller #(
  parameter int ADDR_W  = 64,
  parameter int INSTR_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  pc_out_i,
  output logic [ADDR_W-1:0]  pc_in_o,
  output logic               pc_write_o,
  output logic               imem_req_o,
  output logic [ADDR_W-1:0]  imem_addr_o,
  input  logic               imem_ready_i,
  input  logic               imem_rvalid_i,
  input  logic [INSTR_W-1:0] imem_rdata_i,
  input  logic               redirect_i,
  input  logic [ADDR_W-1:0]  redirect_pc_i,
  input  logic               stall_i,
  output logic               instr_valid_o,
  output logic [INSTR_W-1:0] instr_o,
  output logic [ADDR_W-1:0]  instr_pc_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DROP
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic               r_instr_valid;
  logic [INSTR_W-1:0] r_instr;
  logic [ADDR_W-1:0]  r_instr_pc;
  logic [ADDR_W-1:0]  r_req_pc;

  logic               w_load;
  logic               w_clear_valid;
  logic               w_latch_req;
  logic [ADDR_W-1:0]  w_redirect_target;

  // Redirect targets are forced to word alignment.
  assign w_redirect_target = redirect_pc_i & ~ADDR_W'(3);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_instr_valid <= 1'b0;
      r_instr       <= '0;
      r_instr_pc    <= '0;
      r_req_pc      <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_latch_req)
        r_req_pc <= pc_out_i;
      if (w_load) begin
        r_instr_valid <= 1'b1;
        r_instr       <= imem_rdata_i;
        r_instr_pc    <= r_req_pc;
      end else if (w_clear_valid) begin
        r_instr_valid <= 1'b0;
      end
    end
  end

  always_comb begin
    w_state_next  = r_state;
    imem_req_o    = 1'b0;
    imem_addr_o   = '0;
    pc_write_o    = 1'b0;
    pc_in_o       = '0;
    w_load        = 1'b0;
    w_clear_valid = 1'b0;
    w_latch_req   = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        w_state_next = S_REQ;
      end

      S_REQ: begin
        imem_req_o  = 1'b1;
        imem_addr_o = pc_out_i;
        if (redirect_i) begin
          pc_write_o    = 1'b1;
          pc_in_o       = w_redirect_target;
          w_clear_valid = 1'b1;
          // An accepted request still returns a response that must be discarded.
          w_state_next  = imem_ready_i ? S_DROP : S_REQ;
        end else if (imem_ready_i) begin
          w_latch_req  = 1'b1;
          w_state_next = S_WAIT;
        end
      end

      S_WAIT: begin
        if (redirect_i) begin
          pc_write_o    = 1'b1;
          pc_in_o       = w_redirect_target;
          w_clear_valid = 1'b1;
          w_state_next  = imem_rvalid_i ? S_REQ : S_DROP;
        end else if (imem_rvalid_i) begin
          pc_write_o   = 1'b1;
          pc_in_o      = r_req_pc + ADDR_W'(4);
          w_load       = 1'b1;
          w_state_next = S_HOLD;
        end
      end

      S_HOLD: begin
        if (redirect_i) begin
          pc_write_o    = 1'b1;
          pc_in_o       = w_redirect_target;
          w_clear_valid = 1'b1;
          w_state_next  = S_REQ;
        end else if (!stall_i) begin
          w_clear_valid = 1'b1;
          w_state_next  = S_REQ;
        end
      end

      S_DROP: begin
        if (redirect_i) begin
          pc_write_o    = 1'b1;
          pc_in_o       = w_redirect_target;
          w_clear_valid = 1'b1;
        end
        if (imem_rvalid_i)
          w_state_next = S_REQ;
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  assign instr_valid_o = r_instr_valid;
  assign instr_o       = r_instr;
  assign instr_pc_o    = r_instr_pc;

endmodule
